seg7_scan_controller: RTL and testbench
=======================================

# seg7_scan_controller

Time-multiplexed scan controller that shares one seven-segment decoder and one set of segment lines across `NUM_DIGITS` common-electrode digits. It accepts a packed BCD value through a valid/ready load port, applies it tear-free at frame boundaries, and drives one-hot digit enables with a blanking gap between digits to prevent ghosting. It sits between the seconds/counter logic (BCD producer) and the display pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned. Legal range 1..8.
- `SCAN_COUNT`, 1000: clock cycles each digit is lit. Must be ≥ 1.
- `BLANK_COUNT`, 16: clock cycles of dark gap before each digit. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `load_valid`, in, 1: `load_value` is valid.
- `load_ready`, out, 1: controller can accept a load.
- `load_value`, in, 4*NUM_DIGITS: packed BCD. Nibble 0 is the least significant digit.
- `led_out`, out, 7: segments, active-high, bit0 = a … bit6 = g.
- `digit_en`, out, NUM_DIGITS: one-hot digit enable, active-high. All zero during blanking.
- `frame_start`, out, 1: one-cycle pulse on the first SHOW cycle of digit 0.

## Operation
- Registers:
  - `pending` (4*NUM_DIGITS bits) and `pend_flag`.
  - `display` (4*NUM_DIGITS bits).
  - Digit index `idx` (0..NUM_DIGITS-1).
  - Phase counter `cnt`.
  - State, BLANK or SHOW.
- FSM:
  - BLANK: `digit_en`=0 and `led_out`=0. After BLANK_COUNT cycles, go to SHOW with the same `idx`.
  - SHOW: `digit_en`=1<<`idx` and `led_out`=decode(`display` nibble `idx`). After SCAN_COUNT cycles, go to BLANK and set `idx` to (`idx`+1) mod NUM_DIGITS.
- Frame boundary: the last SHOW cycle of digit NUM_DIGITS-1. On that cycle, if `pend_flag`=1, then `display`←`pending` and `pend_flag`←0.
- Load handshake:
  - `load_ready` = !`pend_flag` (combinational from a register).
  - On `load_valid`&&`load_ready`, `pending`←`load_value` and `pend_flag`←1.
  - A producer must hold `load_valid` and `load_value` stable until accepted.
- Decode:
  - 0..9 use the standard encodings; for example, 0 = 7'b0111111 and 8 = 7'b1111111.
  - Nibbles 10..15 display a dash, 7'b1000000.
- Reset values (asynchronous):
  - State=BLANK, `idx`=0, `cnt`=0.
  - `display`=0, `pending`=0, `pend_flag`=0.
  - `led_out`=0, `digit_en`=0, `frame_start`=0.
  - `load_ready`=1.
- Reset mid-operation aborts the scan immediately. Outputs go dark asynchronously and any pending load is discarded.

## Timing
- All outputs except `load_ready` are registered. They change one cycle after the state/`cnt` transition that causes them.
- Frame length = NUM_DIGITS*(BLANK_COUNT+SCAN_COUNT) cycles.
- The first `digit_en`=1 (digit 0) appears BLANK_COUNT+1 cycles after the first rising edge with `reset` low.
- `digit_en` is never non-zero for two different digits on consecutive cycles. At least BLANK_COUNT dark cycles separate them.
- Load-to-display latency is from acceptance to the first SHOW of digit 0 after the next frame boundary. That is at most one frame plus BLANK_COUNT+1 cycles.
- Simultaneous load and frame boundary: the load is not accepted that cycle because `load_ready`=0. `load_ready` returns to 1 on the following cycle.
- A load accepted during the frame-boundary cycle when `pend_flag`=0 is captured into `pending`. It is applied at the next boundary, not the current one.
- `cnt` width = $clog2(max(SCAN_COUNT,BLANK_COUNT)+1). The counter wraps to 0 on each phase change.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN`, defined:
  - A zero nibble more significant than the most significant non-zero nibble of `display` drives `led_out`=0 during its SHOW phase.
  - `digit_en` still asserts, so scan timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Not defined: every digit shows its decoded nibble, including leading zeros.

## Structure
- Shared package `seg7_pkg`:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Enum `scan_state_t` {BLANK, SHOW}.
- Sub-module `seg7_decode`: combinational 4-bit BCD to 7-segment, instantiated once and fed by the `idx` mux.
- The controller holds the FSM, counters, handshake and leading-zero logic.

## Test plan
Benches use NUM_DIGITS=4, SCAN_COUNT=8, BLANK_COUNT=2.
1. Reset release with no load → digit 0 shows 7'b0111111 with `digit_en`=4'b0001 at cycle 3. The sequence 0001→0010→0100→1000 repeats every 40 cycles with 2 dark cycles between digits.
2. Load 16'h1234 mid-frame → `load_ready` drops. At the next frame boundary, `digit_en`=0001 shows "4" (7'b1100110) and 1000 shows "1" (7'b0000110). `load_ready` returns high.
3. Second load while `pend_flag`=1 → held off until the boundary, then accepted. The first value displays for one full frame before the second.
4. Nibble 4'hB in digit 2 → 7'b1000000 (dash) when `digit_en`=0100.
5. `SEG7_LEADING_ZERO_BLANK_EN` with load 16'h0050 → digits 3 and 2 show `led_out`=0 with enables still cycling. Digit 1 shows "5" and digit 0 shows "0". Load 16'h0000 shows "0" on digit 0 only.
6. Assert `reset` during SHOW of digit 2 with a pending load → `led_out`/`digit_en` go 0 without waiting for a clock edge. After release, digit 0 shows "0" and the pending value is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Definitions shared by the seven-segment scan controller and its decoder:
//   - segment encodings, active-high, bit0 = a ... bit6 = g
//   - the scan phase enum
//   - a small helper used for sizing counters
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational BCD to seven-segment decoder. Codes 10..15 show a dash.
// Ports:
//   bcd_i [3:0] : BCD nibble
//   seg_o [6:0] : segments, active-high, bit0 = a ... bit6 = g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed scan of NUM_DIGITS common-electrode digits sharing one
//   decoder. A BCD value arrives through a valid/ready port, is parked in a
//   pending register, and is copied to the displayed value only on the last
//   SHOW cycle of the most significant digit, so a frame never mixes values.
//   Each digit is preceded by a dark gap to avoid ghosting.
//
//   Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//     When defined, zero digits above the most significant non-zero digit
//     are driven dark during SHOW (digit 0 is always shown).
//
// Ports:
//   clk         : clock
//   reset       : asynchronous active-high reset
//   load_valid  : load_value is valid
//   load_ready  : a load can be accepted (no value pending)
//   load_value  : packed BCD, nibble 0 = least significant digit
//   led_out     : segments, active-high, bit0 = a ... bit6 = g
//   digit_en    : one-hot digit enable, zero during blanking
//   frame_start : one-cycle pulse on the first lit cycle of digit 0
//
// state | meaning
// BLANK | gap before a digit; outputs dark for BLANK_COUNT cycles
// SHOW  | digit idx lit for SCAN_COUNT cycles, then advance idx
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_COUNT  = 1000,
    parameter int BLANK_COUNT = 16
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(max_int(SCAN_COUNT, BLANK_COUNT) + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                 state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [IDX_W-1:0]            idx_q;
    logic [4*NUM_DIGITS-1:0]     display_q, display_d;
    logic [4*NUM_DIGITS-1:0]     pending_q, pending_d;
    logic                        pend_flag_q, pend_flag_d;
    logic [6:0]                  led_q, led_d;
    logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
    logic                        frame_start_q, frame_start_d;

    logic [3:0]                  cur_nibble;
    logic [6:0]                  cur_seg;
    logic                        lz_blank;
    logic                        frame_boundary;
    logic                        load_accept;

    assign load_ready  = !pend_flag_q;
    assign load_accept = load_valid && load_ready;

    assign frame_boundary = (state_q == SHOW) && (cnt_q == SCAN_LAST) &&
                            (idx_q == IDX_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz_mask[i] is set when nibble i and every nibble above it are zero.
    // Digit 0 is excluded so a zero value still shows a single "0".
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  all_zero_above;

    always_comb begin
        lz_mask        = '0;
        all_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero_above = all_zero_above && (display_q[i*4 +: 4] == 4'd0);
            lz_mask[i]     = all_zero_above;
        end
    end
`endif

    // Single shared decoder, fed by the idx mux.
    always_comb begin
        cur_nibble = 4'd0;
        lz_blank   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = display_q[i*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                lz_blank   = lz_mask[i];
`endif
            end
        end
    end

    seg7_decode u_decode (
        .bcd_i (cur_nibble),
        .seg_o (cur_seg)
    );

    always_comb begin
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        display_d   = display_q;
        // A pending value blocks acceptance, so the two branches are exclusive.
        if (frame_boundary && pend_flag_q) begin
            display_d   = pending_q;
            pend_flag_d = 1'b0;
        end else if (load_accept) begin
            pending_d   = load_value;
            pend_flag_d = 1'b1;
        end
    end

    // Output registers mirror the current phase one cycle later.
    always_comb begin
        led_d         = SEG_OFF;
        digit_en_d    = '0;
        frame_start_d = 1'b0;
        if (state_q == SHOW) begin
            digit_en_d    = NUM_DIGITS'(1) << idx_q;
            led_d         = lz_blank ? SEG_OFF : cur_seg;
            frame_start_d = (idx_q == '0) && (cnt_q == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            display_q     <= '0;
            pending_q     <= '0;
            pend_flag_q   <= 1'b0;
            led_q         <= SEG_OFF;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            display_q     <= display_d;
            pending_q     <= pending_d;
            pend_flag_q   <= pend_flag_d;
            led_q         <= led_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;

            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= SHOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign led_out     = led_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller (NUM_DIGITS=4, SCAN_COUNT=8, BLANK_COUNT=2).
// A cycle-position reference model pushes every expected lit cycle into a
// scoreboard queue; a negedge monitor pops and compares whenever a digit is
// enabled and checks darkness otherwise.
module tb_seg7_scan_controller;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int BC    = 2;
    localparam int SLOT  = SC + BC;
    localparam int FRAME = ND * SLOT;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] led;
        logic       fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_value;
    logic [6:0]    led_out;
    logic [3:0]    digit_en;
    logic          frame_start;

    int            n_checks = 0;
    int            n_fail   = 0;

    exp_t          sb[$];

    logic [6:0]    seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

    // Reference model state.
    int            e;
    logic [15:0]   m_display;
    logic [15:0]   m_pending;
    bit            m_pend;
    bit            exp_ready;

    seg7_scan_controller #(
        .NUM_DIGITS  (ND),
        .SCAN_COUNT  (SC),
        .BLANK_COUNT (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .led_out     (led_out),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = v[d*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d != 0 && (v >> (4*d)) == 16'd0)
            return 7'b0000000;
`endif
        return seg_tab[nib];
    endfunction

    // Position model: output after edge e reflects cycle e-1 of the scan,
    // whose place in the frame is (e-1) mod FRAME. Values swap on every
    // edge that ends a frame.
    always @(posedge clk or posedge reset) begin
        int   p, d, q;
        exp_t it;
        if (reset) begin
            e         = 0;
            m_display = '0;
            m_pending = '0;
            m_pend    = 0;
            exp_ready = 1;
            sb.delete();
        end else begin
            e++;
            p = (e - 1) % FRAME;
            d = p / SLOT;
            q = p % SLOT;
            if (q >= BC) begin
                it.en  = 4'(1 << d);
                it.led = exp_seg(m_display, d);
                it.fs  = (p == BC);
                sb.push_back(it);
            end
            if ((e % FRAME) == 0 && m_pend) begin
                m_display = m_pending;
                m_pend    = 0;
            end else if (load_valid && !m_pend) begin
                m_pending = load_value;
                m_pend    = 1;
            end
            exp_ready = !m_pend;
        end
    end

    always @(negedge clk) begin
        exp_t it;
        if (!reset) begin
            check("load_ready", {31'd0, load_ready}, {31'd0, exp_ready});
            if (digit_en != 4'd0) begin
                check("output_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    it = sb.pop_front();
                    check("digit_en", {28'd0, digit_en}, {28'd0, it.en});
                    check("led_out", {25'd0, led_out}, {25'd0, it.led});
                    check("frame_start", {31'd0, frame_start}, {31'd0, it.fs});
                end
            end else begin
                check("dark_led", {25'd0, led_out}, 32'd0);
                check("dark_frame_start", {31'd0, frame_start}, 32'd0);
                check("missing_output", sb.size(), 32'd0);
                sb.delete();
            end
        end
    end

    task automatic do_load(input logic [15:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        load_value = v;
        load_valid = 1'b1;
        while (!load_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("load_accept_timeout", {31'd0, guard >= 200}, 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_en(input logic [3:0] target);
        int guard;
        guard = 0;
        @(negedge clk);
        while (digit_en != target && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_digit_timeout", {31'd0, guard >= 100}, 32'd0);
    endtask

    task automatic wait_fs();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!frame_start && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_frame_timeout", {31'd0, guard >= 100}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        #7;
        check("reset_digit_en", {28'd0, digit_en}, 32'd0);
        check("reset_led_out", {25'd0, led_out}, 32'd0);
        check("reset_frame_start", {31'd0, frame_start}, 32'd0);
        check("reset_load_ready", {31'd0, load_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle frames, then a mid-frame load and a held-off second load.
        repeat (90) @(negedge clk);
        repeat (13) @(negedge clk);
        do_load(16'h1234);
        do_load(16'h5678);
        repeat (100) @(negedge clk);
        do_load(16'h0B00);
        repeat (100) @(negedge clk);
        do_load(16'h0050);
        repeat (100) @(negedge clk);
        do_load(16'h0000);
        repeat (100) @(negedge clk);

        // Reset during SHOW of digit 2 with a load still pending.
        wait_fs();
        do_load(16'h9876);
        wait_en(4'b0100);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_digit_en", {28'd0, digit_en}, 32'd0);
        check("async_reset_led_out", {25'd0, led_out}, 32'd0);
        check("async_reset_load_ready", {31'd0, load_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);

        // Randomized loads with random gaps.
        for (int i = 0; i < 12; i++) begin
            v = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0)
                v = v & 16'h00FF;
            do_load(v);
            repeat ($urandom_range(0, 90)) @(negedge clk);
        end
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
